// File: rtl/icebreaker_dualport_memory.sv
// icebreaker_dualport_memory: banked 32-bit word memory shared by two requestors
// (P0 = instruction fetch, P1 = load/store). Requests to different banks are served in
// the same cycle. A same-bank collision grants one port and holds the other off via gnt.
// Optional feature macro: ICEMEM_RR_ARB_EN selects round-robin arbitration on same-bank
// conflicts. When it is undefined, P1 wins every conflict (fixed priority).
module icebreaker_dualport_memory #(
    parameter int NBANK      = 4,
    parameter int BANK_WORDS = 16384,
    parameter int INTERLEAVE = 0
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic        p0_req,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p0_wr_en,
    input  logic [3:0]  p0_wr_mask,
    output logic        p0_gnt,
    output logic [31:0] p0_rdata,
    output logic        p0_rvalid,
    input  logic        p1_req,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic        p1_wr_en,
    input  logic [3:0]  p1_wr_mask,
    output logic        p1_gnt,
    output logic [31:0] p1_rdata,
    output logic        p1_rvalid
);

    localparam int DATA_W = 32;
    localparam int NB     = $clog2(NBANK);
    localparam int WB     = $clog2(BANK_WORDS);
    localparam int AW     = NB + WB;

    logic [AW-1:0] p0_word, p1_word;
    logic [NB-1:0] p0_bank, p1_bank;
    logic [WB-1:0] p0_idx,  p1_idx;
    logic          conflict;
    logic          p1_wins;

    // Byte offset and bits above the word range are dropped; upper bits alias.
    assign p0_word = p0_addr[2 +: AW];
    assign p1_word = p1_addr[2 +: AW];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{p0_addr[1:0], p0_addr[31:AW+2], p1_addr[1:0], p1_addr[31:AW+2]};

    // Split the word address into bank select and in-bank index
    always_comb begin
        if (INTERLEAVE != 0) begin
            p0_bank = p0_word[NB-1:0];
            p0_idx  = p0_word[NB +: WB];
            p1_bank = p1_word[NB-1:0];
            p1_idx  = p1_word[NB +: WB];
        end else begin
            p0_bank = p0_word[WB +: NB];
            p0_idx  = p0_word[WB-1:0];
            p1_bank = p1_word[WB +: NB];
            p1_idx  = p1_word[WB-1:0];
        end
    end

    assign conflict = p0_req && p1_req && (p0_bank == p1_bank);

`ifdef ICEMEM_RR_ARB_EN
    // Last conflict winner (1 = P1); the other port wins the next conflict
    logic last_win_p1;

    assign p1_wins = ~last_win_p1;

    // Remember the winner, but only on cycles that actually had a conflict
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            last_win_p1 <= 1'b1;
        end else if (conflict) begin
            last_win_p1 <= p1_wins;
        end
    end
`else
    assign p1_wins = 1'b1;
`endif

    assign p0_gnt = p0_req && !(conflict && p1_wins);
    assign p1_gnt = p1_req && !(conflict && !p1_wins);

    // Per-bank access selected from whichever port was granted that bank
    logic              bank_en    [NBANK];
    logic              bank_we    [NBANK];
    logic [3:0]        bank_mask  [NBANK];
    logic [WB-1:0]     bank_idx   [NBANK];
    logic [DATA_W-1:0] bank_wdata [NBANK];
    logic [DATA_W-1:0] bank_rd    [NBANK];

    // Route each granted request to its bank; at most one port owns a bank per cycle
    always_comb begin
        for (int b = 0; b < NBANK; b++) begin
            bank_en[b]    = 1'b0;
            bank_we[b]    = 1'b0;
            bank_mask[b]  = 4'h0;
            bank_idx[b]   = '0;
            bank_wdata[b] = '0;
            if (p1_gnt && (p1_bank == NB'(b))) begin
                bank_en[b]    = 1'b1;
                bank_we[b]    = p1_wr_en;
                bank_mask[b]  = p1_wr_mask;
                bank_idx[b]   = p1_idx;
                bank_wdata[b] = p1_wdata;
            end else if (p0_gnt && (p0_bank == NB'(b))) begin
                bank_en[b]    = 1'b1;
                bank_we[b]    = p0_wr_en;
                bank_mask[b]  = p0_wr_mask;
                bank_idx[b]   = p0_idx;
                bank_wdata[b] = p0_wdata;
            end
        end
    end

    for (genvar g = 0; g < NBANK; g++) begin : g_bank
        logic [DATA_W-1:0] mem [BANK_WORDS];
        logic [DATA_W-1:0] rd_q;

        // Single-ported bank: one masked write or one read per cycle
        always_ff @(posedge clk) begin
            if (bank_en[g]) begin
                if (bank_we[g]) begin
                    for (int i = 0; i < 4; i++) begin
                        if (bank_mask[g][i]) begin
                            mem[bank_idx[g]][8*i +: 8] <= bank_wdata[g][8*i +: 8];
                        end
                    end
                end else begin
                    rd_q <= mem[bank_idx[g]];
                end
            end
        end

        assign bank_rd[g] = rd_q;
    end

    // ---- stage p1: read data available one cycle after the grant ----
    logic          p0_vld_p1, p1_vld_p1;
    logic [NB-1:0] p0_bank_p1, p1_bank_p1;
    logic [31:0]   p0_hold, p1_hold;

    // Read-valid pulses; reset drops any read still in flight
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            p0_vld_p1 <= 1'b0;
            p1_vld_p1 <= 1'b0;
        end else begin
            p0_vld_p1 <= p0_gnt && !p0_wr_en;
            p1_vld_p1 <= p1_gnt && !p1_wr_en;
        end
    end

    // Track which bank holds each port's read result
    always_ff @(posedge clk) begin
        if (p0_gnt && !p0_wr_en) p0_bank_p1 <= p0_bank;
        if (p1_gnt && !p1_wr_en) p1_bank_p1 <= p1_bank;
    end

    // Keep the last delivered word so rdata holds until the port's next read
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            p0_hold <= 32'h0;
            p1_hold <= 32'h0;
        end else begin
            if (p0_vld_p1) p0_hold <= bank_rd[p0_bank_p1];
            if (p1_vld_p1) p1_hold <= bank_rd[p1_bank_p1];
        end
    end

    assign p0_rvalid = p0_vld_p1;
    assign p1_rvalid = p1_vld_p1;
    assign p0_rdata  = p0_vld_p1 ? bank_rd[p0_bank_p1] : p0_hold;
    assign p1_rdata  = p1_vld_p1 ? bank_rd[p1_bank_p1] : p1_hold;

endmodule

// File: tb/tb_icebreaker_dualport_memory.sv
// Scoreboard bench for icebreaker_dualport_memory (NBANK=4, word-interleaved).
// Expectations follow ICEMEM_RR_ARB_EN when the bench is built with it.
module tb_icebreaker_dualport_memory;

    logic        clk = 1'b0;
    logic        rstz = 1'b0;
    logic        p0_req, p0_wr_en, p0_gnt, p0_rvalid;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic [3:0]  p0_wr_mask;
    logic        p1_req, p1_wr_en, p1_gnt, p1_rvalid;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic [3:0]  p1_wr_mask;

    always #5 clk = ~clk;

    icebreaker_dualport_memory #(
        .NBANK(4), .BANK_WORDS(16384), .INTERLEAVE(1)
    ) dut (
        .clk(clk), .rstz(rstz),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wr_en(p0_wr_en),
        .p0_wr_mask(p0_wr_mask), .p0_gnt(p0_gnt), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wr_en(p1_wr_en),
        .p1_wr_mask(p1_wr_mask), .p1_gnt(p1_gnt), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid)
    );

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
    } exp_t;

    exp_t        q0[$], q1[$];
    exp_t        last0, last1;
    logic [31:0] model [65536];
    bit   [3:0]  known [65536];
    int          checks = 0, errors = 0;
    int          rdg0 = 0, rdg1 = 0, rv0 = 0, rv1 = 0;

    function automatic logic [15:0] widx(input logic [31:0] a);
        return a[17:2];
    endfunction

    function automatic bit bmatch(input logic [31:0] a, input logic [31:0] e, input logic [3:0] k);
        for (int i = 0; i < 4; i++)
            if (k[i] && (a[8*i +: 8] != e[8*i +: 8])) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want,
                         input logic [3:0] k);
        checks++;
        if (!bmatch(act, want, k)) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h (byte lanes %b)", name, act, want, k);
        end
    endtask

    // Scoreboard producer: record expected read data at each granting edge, then apply writes
    always @(posedge clk) begin
        exp_t e;
        if (rstz) begin
            if (p0_req && p0_gnt && !p0_wr_en) begin
                e.d = model[widx(p0_addr)]; e.k = known[widx(p0_addr)];
                q0.push_back(e); rdg0++;
            end
            if (p1_req && p1_gnt && !p1_wr_en) begin
                e.d = model[widx(p1_addr)]; e.k = known[widx(p1_addr)];
                q1.push_back(e); rdg1++;
            end
            for (int i = 0; i < 4; i++) begin
                if (p0_req && p0_gnt && p0_wr_en && p0_wr_mask[i]) begin
                    model[widx(p0_addr)][8*i +: 8] = p0_wdata[8*i +: 8];
                    known[widx(p0_addr)][i] = 1'b1;
                end
                if (p1_req && p1_gnt && p1_wr_en && p1_wr_mask[i]) begin
                    model[widx(p1_addr)][8*i +: 8] = p1_wdata[8*i +: 8];
                    known[widx(p1_addr)][i] = 1'b1;
                end
            end
        end
    end

    // Scoreboard consumer: compare on every rvalid, check hold otherwise, check reset values
    always @(negedge clk) begin
        if (!rstz) begin
            q0.delete(); q1.delete();
            last0 = '{32'h0, 4'hF};
            last1 = '{32'h0, 4'hF};
            check("rst_p0_rvalid", {31'b0, p0_rvalid}, 32'h0, 4'hF);
            check("rst_p0_rdata", p0_rdata, 32'h0, 4'hF);
            check("rst_p1_rvalid", {31'b0, p1_rvalid}, 32'h0, 4'hF);
            check("rst_p1_rdata", p1_rdata, 32'h0, 4'hF);
        end else begin
            if (p0_rvalid) begin
                rv0++;
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL p0_rvalid: got 1, expected 0 (no read outstanding)");
                end else begin
                    last0 = q0.pop_front();
                    check("p0_rdata", p0_rdata, last0.d, last0.k);
                end
            end else begin
                check("p0_rdata_hold", p0_rdata, last0.d, last0.k);
            end
            if (p1_rvalid) begin
                rv1++;
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL p1_rvalid: got 1, expected 0 (no read outstanding)");
                end else begin
                    last1 = q1.pop_front();
                    check("p1_rdata", p1_rdata, last1.d, last1.k);
                end
            end else begin
                check("p1_rdata_hold", p1_rdata, last1.d, last1.k);
            end
        end
    end

    // Issue one request from a negedge and hold it until granted; returns at the negedge after the grant
    task automatic op(input int port, input logic [31:0] a, input logic [31:0] d,
                      input bit wr, input logic [3:0] m);
        int n = 0;
        bit g;
        if (port == 0) begin
            p0_req = 1'b1; p0_addr = a; p0_wdata = d; p0_wr_en = wr; p0_wr_mask = m;
        end else begin
            p1_req = 1'b1; p1_addr = a; p1_wdata = d; p1_wr_en = wr; p1_wr_mask = m;
        end
        do begin
            #1;
            g = (port == 0) ? p0_gnt : p1_gnt;
            @(negedge clk);
            n++;
        end while (!g && n < 64);
        if (!g) begin
            checks++; errors++;
            $display("FAIL grant_timeout_p%0d: got no grant, expected grant within 64 cycles", port);
        end
        if (port == 0) p0_req = 1'b0;
        else           p1_req = 1'b0;
    endtask

    task automatic rand_port(input int port);
        logic [31:0] a;
        for (int k = 0; k < 2048; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[17:2] = 16'($urandom_range(0, 63) * 1031);
            op(port, a, $urandom, bit'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef ICEMEM_RR_ARB_EN
        bit win_p1 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        bit win_p1 [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        p0_req = 0; p0_addr = 0; p0_wdata = 0; p0_wr_en = 0; p0_wr_mask = 0;
        p1_req = 0; p1_addr = 0; p1_wdata = 0; p1_wr_en = 0; p1_wr_mask = 0;
        repeat (3) @(negedge clk);
        @(posedge clk); #2 rstz = 1'b1;
        @(negedge clk);

        // Preload through P1
        op(1, 32'h0000_0100, 32'h1122_3344, 1'b1, 4'hF);
        op(1, 32'h0000_0000, 32'hCAFE_F00D, 1'b1, 4'hF);
        op(1, 32'h0000_0010, 32'h0BAD_C0DE, 1'b1, 4'hF);

        // T1: reset lands between the read grant and its rvalid
        p0_req = 1'b1; p0_addr = 32'h0; p0_wr_en = 1'b0; p0_wr_mask = 4'h0;
        #1 check("t1_p0_gnt", {31'b0, p0_gnt}, 32'h1, 4'hF);
        @(posedge clk); #2 rstz = 1'b0; p0_req = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #2 rstz = 1'b1;
        @(negedge clk);
        op(0, 32'h0, 32'h0, 1'b0, 4'h0);
        check("t1_preload_rvalid", {31'b0, p0_rvalid}, 32'h1, 4'hF);
        check("t1_preload_rdata", p0_rdata, 32'hCAFE_F00D, 4'hF);

        // T2: masked write then read-back on P1
        op(1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 4'b0101);
        check("t2_write_no_rvalid", {31'b0, p1_rvalid}, 32'h0, 4'hF);
        op(1, 32'h0000_0100, 32'h0, 1'b0, 4'h0);
        check("t2_rvalid", {31'b0, p1_rvalid}, 32'h1, 4'hF);
        check("t2_rdata", p1_rdata, 32'h11AD_33EF, 4'hF);

        // T3: P0 read bank0 and P1 write bank1 in the same cycle
        p0_req = 1'b1; p0_addr = 32'h0; p0_wr_en = 1'b0;
        p1_req = 1'b1; p1_addr = 32'h4; p1_wdata = 32'h1234_5678; p1_wr_en = 1'b1; p1_wr_mask = 4'hF;
        #1;
        check("t3_p0_gnt", {31'b0, p0_gnt}, 32'h1, 4'hF);
        check("t3_p1_gnt", {31'b0, p1_gnt}, 32'h1, 4'hF);
        @(negedge clk);
        p0_req = 1'b0; p1_req = 1'b0;
        check("t3_p0_rvalid", {31'b0, p0_rvalid}, 32'h1, 4'hF);
        check("t3_p0_rdata", p0_rdata, 32'hCAFE_F00D, 4'hF);
        check("t3_p1_rvalid", {31'b0, p1_rvalid}, 32'h0, 4'hF);
        op(0, 32'h4, 32'h0, 1'b0, 4'h0);
        check("t3_readback", p0_rdata, 32'h1234_5678, 4'hF);

        // T4/T5: continuous same-bank reads on both ports
        p0_req = 1'b1; p0_addr = 32'h0;  p0_wr_en = 1'b0;
        p1_req = 1'b1; p1_addr = 32'h10; p1_wr_en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("conflict_p0_gnt", {31'b0, p0_gnt}, {31'b0, !win_p1[c]}, 4'hF);
            check("conflict_p1_gnt", {31'b0, p1_gnt}, {31'b0, win_p1[c]}, 4'hF);
            @(negedge clk);
        end
        p1_req = 1'b0;
        #1 check("conflict_p0_after_p1_drop", {31'b0, p0_gnt}, 32'h1, 4'hF);
        @(negedge clk);
        p0_req = 1'b0;
        repeat (2) @(negedge clk);

        // T6: random traffic on both ports
        rdg0 = 0; rdg1 = 0; rv0 = 0; rv1 = 0;
        fork
            rand_port(0);
            rand_port(1);
        join
        repeat (3) @(negedge clk);
        check("p0_rvalid_count", rv0, rdg0, 4'hF);
        check("p1_rvalid_count", rv1, rdg1, 4'hF);
        check("queues_drained", q0.size() + q1.size(), 32'h0, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
